// File: rtl/alu_pkg.sv
// alu_pkg: ALU command codes, error bit positions, issuer FSM states and error masking.
package alu_pkg;
  localparam logic [3:0] CMD_NOP = 4'd0;
  localparam logic [3:0] CMD_ADD = 4'd1;
  localparam logic [3:0] CMD_SUB = 4'd2;
  localparam logic [3:0] CMD_MUL = 4'd3;
  localparam logic [3:0] CMD_DIV = 4'd4;
  localparam logic [3:0] CMD_MOD = 4'd5;
  localparam int ERR_DBZ = 1;
  localparam int ERR_OVF = 0;
  typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;
  // Overflow only means something for ADD/SUB, divide-by-zero only for DIV/MOD.
  function automatic logic [1:0] err_mask(input logic [3:0] cmd, input logic [1:0] err);
    logic [1:0] m;
    m = '0;
    m[ERR_OVF] = err[ERR_OVF] & (cmd == CMD_ADD || cmd == CMD_SUB);
    m[ERR_DBZ] = err[ERR_DBZ] & (cmd == CMD_DIV || cmd == CMD_MOD);
    return m;
  endfunction
  function automatic logic is_arith(input logic [3:0] cmd);
    return cmd >= CMD_ADD && cmd <= CMD_MOD;
  endfunction
endpackage

// File: rtl/alu_op_issuer_settle_counter.sv
// settle_counter: 4-bit down counter with load, saturating decrement and zero flag.
module settle_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_i,
  input  logic       dec_i,
  input  logic [3:0] load_val_i,
  output logic       zero_o
);
  logic [3:0] cnt_q, cnt_d;
  always_comb cnt_d = load_i ? load_val_i : (dec_i && cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
  always_ff @(posedge clk) cnt_q <= reset ? 4'd0 : cnt_d;
  assign zero_o = cnt_q == 4'd0;
endmodule

// File: rtl/alu_op_issuer.sv
// alu_op_issuer: holds registered operands on a combinational ALU, waits a settle time, returns result/error.
module alu_op_issuer
  import alu_pkg::*;
#(
  parameter int W             = 16,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [3:0]     req_cmd,
  input  logic [W-1:0]   req_a,
  input  logic [W-1:0]   req_b,
  input  logic           req_use_acc,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [2*W-1:0] rsp_result,
  output logic [1:0]     rsp_error,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  output logic [3:0]     alu_cmd,
  input  logic [2*W-1:0] alu_result,
  input  logic [1:0]     alu_error,
  output logic [2*W-1:0] acc,
  output logic [1:0]     sticky_err,
  input  logic           clr_sticky,
  output logic           busy
);
  state_t state_q, state_d;
  logic [W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [3:0] alu_cmd_q, alu_cmd_d;
  logic [2*W-1:0] rsp_result_q, rsp_result_d, acc_q, acc_d;
  logic [1:0] rsp_error_q, rsp_error_d, sticky_q, sticky_d, err_m;
  logic accept, capture, cnt_zero;
  settle_counter u_cnt (
    .clk       (clk),
    .reset     (reset),
    .load_i    (accept),
    .dec_i     (state_q == SETTLE),
    .load_val_i(4'(SETTLE_CYCLES - 1)),
    .zero_o    (cnt_zero)
  );
  assign accept  = req_valid & req_ready;
  assign capture = (state_q == SETTLE) & cnt_zero;
  assign err_m   = err_mask(alu_cmd_q, alu_error);
  always_ff @(posedge clk) state_q <= reset ? IDLE : state_d;
  always_comb
    state_d = (state_q == IDLE && accept) ? SETTLE :
              capture ? RESP :
              (state_q == RESP && rsp_ready) ? IDLE : state_q;
  always_comb begin
    req_ready = (state_q == IDLE) && !reset;
    busy      = state_q != IDLE;
    rsp_valid = state_q == RESP;
  end
  always_comb begin
    alu_a_d      = accept ? (req_use_acc ? acc_q[W-1:0] : req_a) : alu_a_q;
    alu_b_d      = accept ? req_b : alu_b_q;
    alu_cmd_d    = accept ? req_cmd : alu_cmd_q;
    rsp_result_d = capture ? alu_result : rsp_result_q;
    rsp_error_d  = capture ? err_m : rsp_error_q;
    acc_d        = (capture && is_arith(alu_cmd_q) && !err_m[ERR_DBZ]) ? alu_result : acc_q;
    // A clear landing on the capture edge drops old bits but keeps the new ones.
    sticky_d     = capture ? (clr_sticky ? err_m : sticky_q | err_m) : clr_sticky ? 2'b00 : sticky_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_cmd_q    <= '0;
      rsp_result_q <= '0;
      rsp_error_q  <= '0;
      acc_q        <= '0;
      sticky_q     <= '0;
    end else begin
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_cmd_q    <= alu_cmd_d;
      rsp_result_q <= rsp_result_d;
      rsp_error_q  <= rsp_error_d;
      acc_q        <= acc_d;
      sticky_q     <= sticky_d;
    end
  end
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_cmd    = alu_cmd_q;
  assign rsp_result = rsp_result_q;
  assign rsp_error  = rsp_error_q;
  assign acc        = acc_q;
  assign sticky_err = sticky_q;
endmodule

// File: tb/tb_alu_op_issuer.sv
// tb_alu_op_issuer: directed requests against a behavioural BreadBoard ALU, scoreboard-checked responses.
module tb_alu_op_issuer;
  import alu_pkg::*;
  localparam int W = 16;
  localparam int SC = 4;
  typedef struct packed {
    logic [31:0] res;
    logic [1:0]  err;
    logic [31:0] acc;
    logic [1:0]  st;
  } exp_t;
  logic clk = 0, reset = 1;
  logic req_valid = 0, req_ready, req_use_acc = 0;
  logic [3:0] req_cmd = 0;
  logic [W-1:0] req_a = 0, req_b = 0;
  logic rsp_valid, rsp_ready = 1, clr_sticky = 0, busy;
  logic [2*W-1:0] rsp_result, alu_result, acc;
  logic [1:0] rsp_error, alu_error, sticky_err;
  logic [W-1:0] alu_a, alu_b;
  logic [3:0] alu_cmd;
  int checks = 0, errors = 0, ncyc = 0;
  exp_t exp_q[$];
  int acpt_q[$];
  bit prev_v = 0;
  always #5 clk = ~clk;
  alu_op_issuer #(.W(W), .SETTLE_CYCLES(SC)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
    .req_a(req_a), .req_b(req_b), .req_use_acc(req_use_acc), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_error(rsp_error), .alu_a(alu_a),
    .alu_b(alu_b), .alu_cmd(alu_cmd), .alu_result(alu_result), .alu_error(alu_error),
    .acc(acc), .sticky_err(sticky_err), .clr_sticky(clr_sticky), .busy(busy)
  );
  // BreadBoard stand-in; raises error bits outside their commands so masking is exercised.
  always_comb begin
    alu_result = '0;
    alu_error  = '0;
    case (alu_cmd)
      CMD_ADD: begin alu_result = 32'(alu_a) + 32'(alu_b); alu_error[0] = alu_result[W]; end
      CMD_SUB: begin alu_result = {16'h0, alu_a - alu_b}; alu_error[0] = alu_a < alu_b; end
      CMD_MUL: alu_result = 32'(alu_a) * 32'(alu_b);
      CMD_DIV: alu_result = (alu_b == 0) ? 32'd0 : 32'(alu_a / alu_b);
      CMD_MOD: alu_result = (alu_b == 0) ? 32'd0 : 32'(alu_a % alu_b);
      default: alu_error = 2'b11;
    endcase
    if (alu_b == 0) alu_error[1] = 1'b1;
  end
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask
  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout/missing expected=event", name);
  endtask
  function automatic exp_t mk(input logic [31:0] r, input logic [1:0] e, input logic [31:0] a, input logic [1:0] s);
    mk.res = r; mk.err = e; mk.acc = a; mk.st = s;
  endfunction
  always @(negedge clk) begin
    exp_t e;
    ncyc++;
    if (req_valid && req_ready) acpt_q.push_back(ncyc);
    if (rsp_valid && !prev_v) begin
      if (acpt_q.size() == 0) fail("latency_noaccept");
      else check("latency", 64'(ncyc - acpt_q.pop_front()), 64'(SC + 1));
    end
    if (rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) fail("unexpected_rsp");
      else begin
        e = exp_q.pop_front();
        check("rsp_result", 64'(rsp_result), 64'(e.res));
        check("rsp_error", 64'(rsp_error), 64'(e.err));
        check("acc", 64'(acc), 64'(e.acc));
        check("sticky_err", 64'(sticky_err), 64'(e.st));
      end
    end
    prev_v = rsp_valid;
  end
  task automatic issue(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic ua, input exp_t e, input bit want);
    int n = 0;
    if (want) exp_q.push_back(e);
    req_cmd = c; req_a = a; req_b = b; req_use_acc = ua; req_valid = 1;
    do begin @(negedge clk); n++; end while (!req_ready && n < 40);
    if (!req_ready) fail("accept_timeout");
    @(posedge clk); #1 req_valid = 0;
  endtask
  task automatic wait_idle();
    int n = 0;
    do begin @(negedge clk); n++; end while (busy && n < 40);
    if (busy) fail("idle_timeout");
    @(posedge clk); #1;
  endtask
  task automatic op(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                    input logic ua, input exp_t e);
    issue(c, a, b, ua, e, 1);
    wait_idle();
  endtask
  initial begin
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk) check("req_ready_in_reset", 64'(req_ready), 0);
    @(posedge clk); #1 reset = 0;
    @(negedge clk);
    check("rst_alu", 64'({alu_a, alu_b, alu_cmd}), 0);
    check("rst_rsp", 64'({rsp_valid, rsp_result, rsp_error}), 0);
    check("rst_acc_sticky", 64'({acc, sticky_err}), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_req_ready", 64'(req_ready), 1);
    @(posedge clk); #1;
    op(CMD_ADD, 249, 69, 0, mk(318, 0, 318, 0));
    op(CMD_SUB, 249, 69, 0, mk(180, 0, 180, 0));
    op(CMD_MUL, 249, 69, 0, mk(17181, 0, 17181, 0));
    op(CMD_DIV, 249, 69, 0, mk(3, 0, 3, 0));
    op(CMD_MOD, 249, 69, 0, mk(42, 0, 42, 0));
    op(CMD_DIV, 10, 0, 0, mk(0, 2'b10, 42, 2'b10));
    clr_sticky = 1;
    @(posedge clk); #1 clr_sticky = 0;
    @(negedge clk) check("sticky_clear", 64'(sticky_err), 0);
    @(posedge clk); #1;
    op(CMD_ADD, 5, 7, 0, mk(12, 0, 12, 0));
    op(CMD_ADD, 999, 30, 1, mk(42, 0, 42, 0));
    op(CMD_MUL, 999, 2, 1, mk(84, 0, 84, 0));
    op(CMD_MUL, 3, 0, 0, mk(0, 0, 0, 0));
    op(CMD_ADD, 16'hFFFF, 1, 0, mk(65536, 2'b01, 65536, 2'b01));
    op(CMD_SUB, 999, 2, 1, mk(65534, 2'b01, 65534, 2'b01));
    clr_sticky = 1;
    op(CMD_DIV, 7, 0, 0, mk(0, 2'b10, 65534, 2'b10));
    clr_sticky = 0;
    rsp_ready = 0;
    issue(CMD_ADD, 100, 200, 0, mk(300, 0, 300, 0), 1);
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid && n < 20);
    if (!rsp_valid) fail("rsp_valid_timeout");
    @(posedge clk); #1;
    exp_q.push_back(mk(30, 0, 30, 0));
    req_cmd = CMD_SUB; req_a = 50; req_b = 20; req_use_acc = 0; req_valid = 1;
    repeat (6) begin
      @(negedge clk);
      check("bp_rsp_valid", 64'(rsp_valid), 1);
      check("bp_rsp_result", 64'(rsp_result), 300);
      check("bp_alu_a", 64'(alu_a), 100);
      check("bp_alu_b", 64'(alu_b), 200);
      check("bp_alu_cmd", 64'(alu_cmd), 64'(CMD_ADD));
      check("bp_req_ready", 64'(req_ready), 0);
    end
    @(posedge clk); #1 rsp_ready = 1;
    n = 0;
    do begin @(negedge clk); n++; end while (!req_ready && n < 20);
    if (!req_ready) fail("bp_accept_timeout");
    @(posedge clk); #1 req_valid = 0;
    wait_idle();
    issue(CMD_MUL, 9, 9, 0, mk(0, 0, 0, 0), 0);
    @(posedge clk); #1;
    @(posedge clk); #1 reset = 1;
    @(posedge clk); #1 reset = 0;
    acpt_q.delete();
    @(negedge clk);
    check("mid_rst_alu", 64'({alu_a, alu_b, alu_cmd}), 0);
    check("mid_rst_rsp", 64'({rsp_valid, rsp_result, rsp_error}), 0);
    check("mid_rst_acc_sticky", 64'({acc, sticky_err}), 0);
    check("mid_rst_busy", 64'(busy), 0);
    repeat (8) @(negedge clk) check("mid_rst_no_rsp", 64'(rsp_valid), 0);
    @(posedge clk); #1;
    op(CMD_ADD, 16'hFFFF, 1, 0, mk(65536, 2'b01, 65536, 2'b01));
    op(4'd9, 100, 3, 0, mk(0, 0, 65536, 2'b01));
    check("drain_exp", 64'(exp_q.size()), 0);
    check("drain_accept", 64'(acpt_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/alu_op_issuer.md
Name: alu_op_issuer

Overview:
- Client/initiator side of the BreadBoard ALU command interface (inputA/inputB/command -> result/error).
- Accepts operation requests over a valid/ready handshake and drives registered, stable operands and command into the combinational ALU.
- Waits a fixed settle time for the ripple-carry/array logic, then captures result and error into a response channel.
- Keeps a 32-bit accumulator for chained operations and a sticky error register.

Parameters:
- W, 16, operand width; must match the ALU inputs. Result width is 2*W.
- SETTLE_CYCLES, 4, number of cycles the ALU inputs are held before capture; legal range 1..15.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  issuer can accept a request.
- req_cmd  in  4  ALU command: 0 NOP, 1 ADD, 2 SUB, 3 MUL, 4 DIV, 5 MOD, 6-15 reserved.
- req_a  in  W  operand A.
- req_b  in  W  operand B.
- req_use_acc  in  1  when 1, operand A is taken from acc[W-1:0] instead of req_a.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_result  out  2W  captured ALU result.
- rsp_error  out  2  captured error: bit1 divide-by-zero, bit0 overflow.
- alu_a  out  W  to ALU inputA (registered).
- alu_b  out  W  to ALU inputB (registered).
- alu_cmd  out  4  to ALU command (registered).
- alu_result  in  2W  from ALU result.
- alu_error  in  2  from ALU error.
- acc  out  2W  accumulator.
- sticky_err  out  2  OR of all masked errors since reset or last clear.
- clr_sticky  in  1  clears sticky_err.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Clocking and reset:
  - Single clock, clk.
  - reset is synchronous, active-high.
  - On reset: state IDLE; alu_a, alu_b, alu_cmd, rsp_result, rsp_error, acc, sticky_err all 0; rsp_valid 0.
- FSM states: IDLE, SETTLE, RESP.
  - req_ready = (state == IDLE) and not reset. busy = (state != IDLE).
- IDLE:
  - On req_valid & req_ready: alu_a <= req_use_acc ? acc[W-1:0] : req_a; alu_b <= req_b; alu_cmd <= req_cmd.
  - Same edge: cnt <= SETTLE_CYCLES-1; go to SETTLE.
  - Without a handshake, alu_* hold their previous values.
- SETTLE:
  - alu_* held constant.
  - If cnt != 0: cnt decrements.
  - If cnt == 0, capture and go to RESP:
    - rsp_result <= alu_result.
    - rsp_error <= masked alu_error.
    - acc and sticky_err update per the rules below.
- RESP:
  - rsp_valid = 1. rsp_result, rsp_error and alu_* are held until rsp_ready.
  - On rsp_ready, go to IDLE. A new request is not accepted in the same cycle.
- Latency:
  - Request accepted at edge N gives rsp_valid high after edge N+SETTLE_CYCLES.
  - Minimum turnaround is SETTLE_CYCLES+2 cycles per operation.
- Error masking:
  - bit0 (overflow) is kept only for cmd 1 and 2.
  - bit1 (dbz) is kept only for cmd 4 and 5.
  - All other commands report 00.
- Accumulator:
  - At capture, acc <= alu_result for cmd 1..5 unless masked bit1 is set.
  - On DBZ, and for cmd 0 or 6-15, acc is unchanged.
  - Overflow does not block the update.
- Reserved commands (6-15): issued as-is; the ALU returns 0; rsp_error 00.
- Sticky errors:
  - At capture, sticky_err <= sticky_err | masked error.
  - clr_sticky in any cycle zeroes sticky_err.
  - If the clear coincides with a capture, the new error bits are set (capture wins).
- Reset mid-operation: the transaction is dropped and no response is produced; acc clears.
- Arithmetic: the issuer performs no arithmetic. Operands are unsigned W-bit and the result is passed through unmodified.

Decomposition:
- Shared package alu_pkg holds:
  - Command constants CMD_NOP=0, CMD_ADD=1, CMD_SUB=2, CMD_MUL=3, CMD_DIV=4, CMD_MOD=5.
  - Error bit indices ERR_DBZ=1, ERR_OVF=0.
  - The FSM state enum.
  - The error-mask function.
- One natural sub-module, settle_counter: load / decrement / zero-flag, 4-bit.
- Bench instantiates BreadBoard as the ALU behind alu_*.

Test Plan:
- Basic ops with A=249, B=69, cmd 1,2,3,4,5 in sequence, SETTLE_CYCLES=4:
  - rsp_result = 318, 180, 17181, 3, 42; rsp_error = 00 each.
  - rsp_valid rises exactly 4 cycles after each accept.
- Divide by zero, A=10, B=0, cmd 4:
  - rsp_error = 10; acc keeps its prior value (42); sticky_err = 10.
  - Then clr_sticky gives sticky_err = 00.
- Accumulator chain: ADD 5+7 (acc=12), then use_acc ADD b=30 gives rsp_result 42, then use_acc MUL b=2 gives 84; acc = 84.
- Backpressure: hold rsp_ready=0 for 6 cycles after rsp_valid.
  - rsp_result, alu_a, alu_b, alu_cmd stable; req_ready=0; a pending req_valid is not accepted.
  - It is accepted in IDLE after release.
- Reset mid-SETTLE: assert reset 2 cycles after accept.
  - Next cycle: all outputs 0, state IDLE, no rsp_valid ever produced for that request.
- Reserved cmd 9 with A=100, B=3: rsp_result = 0, rsp_error = 00, acc unchanged, sticky unchanged.
